sel_result_misr: RTL and testbench
==================================

// Module: sel_result_misr
// PURPOSE
//  Downstream signature stage for the select-path test benches. It consumes the
//  per-cycle 64-bit result vector that the select logic produces and skips a
//  warm-up period. It then compresses a fixed window of beats into a MISR
//  signature. At window end it compares the signature against an expected
//  constant and reports done/pass.
// PARAMETERS
//  DATA_W   64  width of result word and signature; must be >= 4
//  WARMUP   9   accepted beats discarded after start; signature held at 0; 0 = none
//  WINDOW   90  accepted beats folded into signature; must be >= 1
// PORTS
//  clk        in   1       single clock; all state updates on posedge
//  rst_n      in   1       asynchronous, active-low reset
//  start      in   1       pulse: begin a run; honoured only in IDLE or DONE
//  in_valid   in   1       result word valid this cycle
//  in_ready   out  1       stage accepts a word; beat = in_valid & in_ready
//  in_data    in   DATA_W  result word
//  expected   in   DATA_W  golden signature; sampled in CHECK
//  busy       out  1       high in WARMUP, ACCUM, CHECK
//  done       out  1       high in DONE; held until next start
//  pass       out  1       signature == expected; valid only while done
//  signature  out  DATA_W  current MISR value
// BEHAVIOUR
//  - Reset (async assert, sync deassert at flop level): state=IDLE, signature=0,
//    count=0, in_ready=0, busy=0, done=0, pass=0.
//  - States: IDLE -> WARMUP -> ACCUM -> CHECK -> DONE -> (start) WARMUP.
//  - start in IDLE/DONE:
//    - clears signature, count, done and pass;
//    - enters WARMUP, or ACCUM directly when WARMUP==0.
//    - start is ignored while busy.
//  - in_ready is high in WARMUP and ACCUM only, so there is no backpressure
//    inside a run.
//  - WARMUP: each beat increments count; signature stays 0.
//    - On the WARMUP-th beat: count=0, go to ACCUM.
//  - ACCUM: each beat updates signature as
//      sig <= in_data ^ {sig[DATA_W-2:0], sig[DATA_W-1]^sig[2]^sig[0]}
//    - Cycles without a beat hold sig and count.
//    - On the WINDOW-th beat: go to CHECK.
//  - CHECK: one cycle. pass <= (signature == expected), go to DONE.
//    - Latency: last beat to done=1 is 2 cycles.
//  - DONE: signature, pass and done hold. A beat offered here is not accepted
//    (in_ready=0).
//  - count width: $clog2(max(WARMUP,WINDOW)+1). Comparisons are exact with no
//    wrap. All arithmetic is unsigned and modulo 2^DATA_W.
//  - start coincident with a beat in DONE: the beat is not accepted. The first
//    beat of the new run can be accepted the cycle after start.
//  - rst_n low mid-run returns to IDLE immediately; no partial done/pass is reported.
// STRUCTURE
//  - Package sel_sig_pkg holds:
//    - typedef enum sig_state_e {S_IDLE,S_WARMUP,S_ACCUM,S_CHECK,S_DONE};
//    - localparam DEF_SIG_W=64;
//    - the feedback tap positions (DATA_W-1, 2, 0).
//  - One sub-module, misr_step: a purely combinational next-signature function
//    (sig, data -> sig_next). Top level holds the FSM, counter and registers.
// TESTING
//  1. Reset mid-ACCUM (rst_n low 1 cycle) -> state IDLE, signature=0, done=0,
//     pass=0, in_ready=0 same cycle.
//  2. WARMUP=0, WINDOW=2, start, beats 64'h1 then 64'h0 -> signature 64'h1
//     then 64'h3. With expected=64'h3: done=1, pass=1 two cycles after the
//     second beat.
//  3. WARMUP=2, WINDOW=1: beats 64'hFFFF, 64'hAAAA, 64'h5 -> the two warm-up
//     beats are ignored. Signature=64'h5; with expected=64'h6: pass=0, done=1.
//  4. in_valid gaps during ACCUM (valid toggling 1,0,0,1) -> signature updates
//     only on valid cycles, and the beat count is unaffected by the gaps.
//  5. start pulsed while busy -> ignored, run completes normally. start in
//     DONE -> signature=0, done=0 next cycle, new run proceeds.
//  6. Default params, in_data = bench CRC stream seeded 64'h5aef0c8d_d70a4497
//     -> final signature matches the golden model; pass=1 iff expected equals it.

Source files
------------

// File: rtl/sel_sig_pkg.sv
// Shared types and MISR tap definitions for the select-path signature stage.
package sel_sig_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_ACCUM,
    S_CHECK,
    S_DONE
  } sig_state_e;

  localparam int unsigned DEF_SIG_W = 64;

  // Feedback taps: top bit (width dependent), bit 2 and bit 0.
  localparam int unsigned TAP_MID = 2;
  localparam int unsigned TAP_LO  = 0;

  function automatic int unsigned tap_hi(input int unsigned w);
    return w - 1;
  endfunction

endpackage

// File: rtl/misr_step.sv
// Combinational MISR next-state: shift left, fold feedback into bit 0, XOR data.
module misr_step
  import sel_sig_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_SIG_W
) (
  input  logic [DATA_W-1:0] sig_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] sig_next_o
);

  localparam int unsigned TAP_HI = tap_hi(DATA_W);

  logic fb;

  always_comb begin
    fb         = sig_i[TAP_HI] ^ sig_i[TAP_MID] ^ sig_i[TAP_LO];
    sig_next_o = data_i ^ {sig_i[DATA_W-2:0], fb};
  end

endmodule

// File: rtl/sel_result_misr.sv
// Signature stage: skip WARMUP beats, fold WINDOW beats into a MISR, compare
// against the expected signature and hold done/pass until the next start.
module sel_result_misr
  import sel_sig_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_SIG_W,
  parameter int unsigned WARMUP = 9,
  parameter int unsigned WINDOW = 90
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] expected,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-1:0] signature
);

  localparam int unsigned CNT_MAX = (WARMUP > WINDOW) ? WARMUP : WINDOW;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  sig_state_e        state_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] sig_q;
  logic [DATA_W-1:0] sig_d;
  logic              in_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;

  logic              beat;
  logic [31:0]       cnt_inc;
  logic              last_warm;
  logic              last_win;

  misr_step #(.DATA_W(DATA_W)) u_step (
    .sig_i      (sig_q),
    .data_i     (in_data),
    .sig_next_o (sig_d)
  );

  always_comb begin
    beat      = in_valid & in_ready_q;
    cnt_inc   = 32'(count_q) + 32'd1;
    last_warm = (cnt_inc == WARMUP);
    last_win  = (cnt_inc == WINDOW);
  end

  // in_ready/busy/done are registered alongside the state so each output
  // changes on the same edge as the state transition that implies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      sig_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            sig_q      <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= (WARMUP == 0) ? S_ACCUM : S_WARMUP;
          end
        end
        S_WARMUP: begin
          if (beat) begin
            if (last_warm) begin
              count_q <= '0;
              state_q <= S_ACCUM;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        S_ACCUM: begin
          if (beat) begin
            sig_q   <= sig_d;
            count_q <= count_q + 1'b1;
            if (last_win) begin
              in_ready_q <= 1'b0;
              state_q    <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          pass_q  <= (sig_q == expected);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = in_ready_q;
    busy      = busy_q;
    done      = done_q;
    pass      = pass_q;
    signature = sig_q;
  end

endmodule

// File: tb/tb_sel_result_misr.sv
// Scoreboard bench for sel_result_misr: three instances with different
// warm-up/window settings share one clock and reset.
module tb_sel_result_misr;

  localparam int NI = 3;
  localparam logic [63:0] SEED = 64'h5aef0c8d_d70a4497;
  localparam logic [63:0] POLY = 64'h42F0E1EBA9EA3693;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start    [NI];
  logic        in_valid [NI];
  logic        in_ready [NI];
  logic        busy     [NI];
  logic        done     [NI];
  logic        pass     [NI];
  logic [63:0] in_data  [NI];
  logic [63:0] expected [NI];
  logic [63:0] sig      [NI];

  typedef struct {
    int          u;
    logic [63:0] v;
  } sb_t;

  sb_t         sb_q[$];
  logic [63:0] msig  [NI];
  int unsigned mwarm [NI];
  int unsigned mwin  [NI];
  bit          mbusy [NI];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  sel_result_misr #(.DATA_W(64), .WARMUP(0), .WINDOW(2)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .in_data(in_data[0]), .expected(expected[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .signature(sig[0])
  );

  sel_result_misr #(.DATA_W(64), .WARMUP(2), .WINDOW(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .in_data(in_data[1]), .expected(expected[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .signature(sig[1])
  );

  sel_result_misr #(.DATA_W(64), .WARMUP(9), .WINDOW(90)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .in_data(in_data[2]), .expected(expected[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .signature(sig[2])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned pw(input int u);
    case (u)
      0:       return 0;
      1:       return 2;
      default: return 9;
    endcase
  endfunction

  function automatic int unsigned pn(input int u);
    case (u)
      0:       return 2;
      1:       return 1;
      default: return 90;
    endcase
  endfunction

  function automatic logic [63:0] misr_ref(input logic [63:0] s, input logic [63:0] d);
    return d ^ {s[62:0], s[63] ^ s[2] ^ s[0]};
  endfunction

  function automatic logic [63:0] crc_next(input logic [63:0] c);
    return {c[62:0], 1'b0} ^ (c[63] ? POLY : 64'd0);
  endfunction

  // Drive one cycle of inputs at the falling edge; push the expected
  // signature for any beat the reference model says will be accepted.
  task automatic drive(input int u, input bit st, input bit v, input logic [63:0] d);
    sb_t e;
    @(negedge clk);
    start[u]    = st;
    in_valid[u] = v;
    in_data[u]  = d;
    if (v && mbusy[u] && (mwarm[u] + mwin[u] > 0)) begin
      e.u = u;
      if (mwarm[u] > 0) begin
        mwarm[u]--;
        e.v = 64'd0;
      end else begin
        msig[u] = misr_ref(msig[u], d);
        mwin[u]--;
        e.v = msig[u];
      end
      sb_q.push_back(e);
    end
    if (st && !mbusy[u]) begin
      mbusy[u] = 1'b1;
      msig[u]  = 64'd0;
      mwarm[u] = pw(u);
      mwin[u]  = pn(u);
    end
  endtask

  task automatic expect_done(input int u, input logic [63:0] exp_val, input bit exp_pass);
    @(negedge clk);
    start[u]    = 1'b0;
    in_valid[u] = 1'b0;
    expected[u] = exp_val;
    check("check_busy", 64'(busy[u]), 64'd1);
    check("check_not_done", 64'(done[u]), 64'd0);
    @(negedge clk);
    check("done", 64'(done[u]), 64'd1);
    check("pass", 64'(pass[u]), 64'(exp_pass));
    check("busy_low", 64'(busy[u]), 64'd0);
    check("ready_low", 64'(in_ready[u]), 64'd0);
    mbusy[u] = 1'b0;
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_mon
    bit  p;
    sb_t e;
    always begin
      @(negedge clk);
      #2;
      p = in_valid[g] && in_ready[g];
      @(posedge clk);
      #1;
      if (p) begin
        if (sb_q.size() == 0) begin
          check("beat_unexpected", 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q.pop_front();
          check("sb_inst", 64'(e.u), 64'(g));
          check("sb_sig", sig[g], e.v);
        end
      end
    end
  end

  initial begin
    int          i;
    bit          v;
    logic [63:0] crc;
    logic [63:0] golden;

    for (int u = 0; u < NI; u++) begin
      start[u] = 1'b0; in_valid[u] = 1'b0; in_data[u] = '0; expected[u] = '0;
      msig[u] = '0; mwarm[u] = 0; mwin[u] = 0; mbusy[u] = 1'b0;
    end

    #12;
    for (int u = 0; u < NI; u++) begin
      check("rst_ready", 64'(in_ready[u]), 64'd0);
      check("rst_busy", 64'(busy[u]), 64'd0);
      check("rst_done", 64'(done[u]), 64'd0);
      check("rst_pass", 64'(pass[u]), 64'd0);
      check("rst_sig", sig[u], 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // No warm-up, two-beat window
    drive(0, 1'b1, 1'b0, 64'd0);
    @(posedge clk); #1;
    check("a_ready_after_start", 64'(in_ready[0]), 64'd1);
    check("a_busy_after_start", 64'(busy[0]), 64'd1);
    drive(0, 1'b0, 1'b1, 64'h1);
    @(posedge clk); #1;
    check("a_sig_beat1", sig[0], 64'h1);
    drive(0, 1'b0, 1'b1, 64'h0);
    @(posedge clk); #1;
    check("a_sig_beat2", sig[0], 64'h3);
    expect_done(0, 64'h3, 1'b1);

    // Two warm-up beats discarded, one-beat window, mismatching expected
    drive(1, 1'b1, 1'b0, 64'd0);
    drive(1, 1'b0, 1'b1, 64'hFFFF);
    drive(1, 1'b0, 1'b1, 64'hAAAA);
    @(posedge clk); #1;
    check("b_sig_after_warmup", sig[1], 64'h0);
    drive(1, 1'b0, 1'b1, 64'h5);
    @(posedge clk); #1;
    check("b_sig_final", sig[1], 64'h5);
    expect_done(1, 64'h6, 1'b0);

    // Restart from DONE, then valid gaps inside the window
    drive(0, 1'b1, 1'b0, 64'd0);
    @(posedge clk); #1;
    check("a_restart_done_clr", 64'(done[0]), 64'd0);
    check("a_restart_sig_clr", sig[0], 64'd0);
    drive(0, 1'b0, 1'b1, 64'h7);
    drive(0, 1'b0, 1'b0, 64'hDEAD);
    drive(0, 1'b0, 1'b0, 64'hBEEF);
    @(posedge clk); #1;
    check("a_gap_hold_sig", sig[0], 64'h7);
    check("a_gap_still_busy", 64'(busy[0]), 64'd1);
    drive(0, 1'b0, 1'b1, 64'h9);
    expect_done(0, 64'h7, 1'b1);

    // Default window on the CRC stream, with a start pulse while busy
    crc = SEED;
    drive(2, 1'b1, 1'b0, 64'd0);
    i = 0;
    while (mwin[2] > 0 && i < 400) begin
      v = ((i % 7) != 3);
      drive(2, (i == 40), v, v ? crc : 64'd0);
      if (v) crc = crc_next(crc);
      i++;
    end
    golden = msig[2];
    expect_done(2, golden, 1'b1);
    check("c_final_sig", sig[2], golden);

    // Start in DONE together with a valid word: word must not be taken
    drive(2, 1'b1, 1'b1, crc);
    @(posedge clk); #1;
    check("c_restart_done_clr", 64'(done[2]), 64'd0);
    check("c_restart_sig_clr", sig[2], 64'd0);
    check("c_restart_ready", 64'(in_ready[2]), 64'd1);
    crc = SEED;
    i = 0;
    while (mwin[2] > 0 && i < 400) begin
      v = ((i % 5) != 2);
      drive(2, 1'b0, v, v ? crc : 64'd0);
      if (v) crc = crc_next(crc);
      i++;
    end
    expect_done(2, msig[2] ^ 64'd1, 1'b0);

    // Reset in the middle of ACCUM
    drive(2, 1'b1, 1'b0, 64'd0);
    for (int k = 0; k < 11; k++) begin
      drive(2, 1'b0, 1'b1, 64'h100 + 64'(k));
    end
    @(negedge clk);
    in_valid[2] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(in_ready[2]), 64'd0);
    check("mid_rst_busy", 64'(busy[2]), 64'd0);
    check("mid_rst_done", 64'(done[2]), 64'd0);
    check("mid_rst_pass", 64'(pass[2]), 64'd0);
    check("mid_rst_sig", sig[2], 64'd0);
    check("mid_rst_other_done", 64'(done[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int u = 0; u < NI; u++) mbusy[u] = 1'b0;
    repeat (2) @(negedge clk);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
